// File: rtl/ctrl_pipe_exc.sv
// Control-bundle pipeline for the MIPS core: per-stage stall/flush with bubbles,
// sticky exception tracking, and precise exception commit at EXC_STAGE.
module ctrl_pipe_exc #(
  parameter int unsigned CW        = 16,
  parameter int unsigned STAGES    = 4,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned EXC_STAGE = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic                    in_valid,
  input  logic [CW-1:0]           in_ctrl,
  input  logic [PC_W-1:0]         in_pc,
  input  logic                    in_ds,
  input  logic [STAGES-1:0]       exc_set,
  input  logic [5*STAGES-1:0]     exc_code,
  output logic [STAGES-1:0]       valid_q,
  output logic [CW*STAGES-1:0]    ctrl_q,
  output logic [PC_W*STAGES-1:0]  pc_q,
  output logic [STAGES-1:0]       ds_q,
  output logic                    exc_take,
  output logic [4:0]              exc_code_o,
  output logic [PC_W-1:0]         exc_epc,
  output logic                    exc_bd,
  output logic [CNT_W-1:0]        exc_cnt
);

  localparam int unsigned EW = 5;

  typedef struct packed {
    logic            valid;
    logic [CW-1:0]   ctrl;
    logic [PC_W-1:0] pc;
    logic            ds;
    logic            exc;
    logic [EW-1:0]   code;
  } stage_t;

  stage_t           stg_q [STAGES];
  logic             exc_kill;
  logic             eff_exc_c;
  logic [EW-1:0]    eff_code_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign exc_kill = exc_take;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam bit KILLABLE = (s <= EXC_STAGE);

    stage_t st_d, st_q, load_c;
    logic   bubble_c;
    logic   own_det_c;

    if (s == 0) begin : g_head
      assign bubble_c = 1'b0;
      // Stage 0 loads the decoder inputs; an absent instruction becomes a zeroed bubble.
      always_comb begin
        load_c = '0;
        if (in_valid) begin
          load_c.valid = 1'b1;
          load_c.ctrl  = in_ctrl;
          load_c.pc    = in_pc;
          load_c.ds    = in_ds;
        end
      end
    end else begin : g_body
      localparam bit PREV_KILLABLE = ((s - 1) <= EXC_STAGE);
      stage_t prev;
      logic   det_c;

      assign prev     = stg_q[s-1];
      assign bubble_c = stall[s-1] | (exc_kill & PREV_KILLABLE);
      assign det_c    = exc_set[s-1] & prev.valid & PREV_KILLABLE;

      // Oldest detection keeps its code as the instruction advances.
      always_comb begin
        load_c     = prev;
        load_c.exc = prev.exc | det_c;
        if (!prev.exc) begin
          load_c.code = det_c ? exc_code[EW*(s-1) +: EW] : '0;
        end
      end
    end

    assign own_det_c = exc_set[s] & st_q.valid & KILLABLE;

    always_comb begin
      st_d = st_q;
      if (exc_kill && KILLABLE) begin
        st_d = '0;
      end else if (flush[s]) begin
        st_d = '0;
      end else if (stall[s]) begin
        if (own_det_c && !st_q.exc) begin
          st_d.exc  = 1'b1;
          st_d.code = exc_code[EW*s +: EW];
        end
      end else if (bubble_c) begin
        st_d = '0;
      end else begin
        st_d = load_c;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        st_q <= '0;
      end else begin
        st_q <= st_d;
      end
    end

    assign stg_q[s]             = st_q;
    assign valid_q[s]           = st_q.valid;
    assign ctrl_q[CW*s +: CW]   = st_q.ctrl;
    assign pc_q[PC_W*s +: PC_W] = st_q.pc;
    assign ds_q[s]              = st_q.ds;
  end

  // Commit: same-cycle detection at the commit stage counts, sticky code wins.
  always_comb begin
    eff_exc_c  = stg_q[EXC_STAGE].exc | exc_set[EXC_STAGE];
    eff_code_c = stg_q[EXC_STAGE].exc ? stg_q[EXC_STAGE].code
                                      : exc_code[EW*EXC_STAGE +: EW];
    exc_take   = 1'b0;
    exc_code_o = '0;
    exc_epc    = '0;
    exc_bd     = 1'b0;
    if (stg_q[EXC_STAGE].valid && eff_exc_c) begin
      exc_take   = 1'b1;
      exc_code_o = eff_code_c;
      exc_bd     = stg_q[EXC_STAGE].ds;
      exc_epc    = stg_q[EXC_STAGE].ds ? (stg_q[EXC_STAGE].pc - PC_W'(4))
                                       : stg_q[EXC_STAGE].pc;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (exc_take && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign exc_cnt = cnt_q;

  // Detection bits beyond the commit stage and the last stage's sticky state are intentionally dropped.
  logic unused_sink;
  assign unused_sink = ^{exc_set, exc_code, stg_q[STAGES-1].exc, stg_q[STAGES-1].code,
                         stg_q[EXC_STAGE].ctrl};

endmodule

// File: tb/tb_ctrl_pipe_exc.sv
// Directed self-checking bench for ctrl_pipe_exc with default parameters.
module tb_ctrl_pipe_exc;

  localparam int unsigned CW = 16, S = 4, PW = 32, CNTW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [S-1:0]      stall, flush, exc_set;
  logic              in_valid, in_ds;
  logic [CW-1:0]     in_ctrl;
  logic [PW-1:0]     in_pc;
  logic [5*S-1:0]    exc_code;
  logic [S-1:0]      valid_q, ds_q;
  logic [CW*S-1:0]   ctrl_q;
  logic [PW*S-1:0]   pc_q;
  logic              exc_take, exc_bd;
  logic [4:0]        exc_code_o;
  logic [PW-1:0]     exc_epc;
  logic [CNTW-1:0]   exc_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_pipe_exc dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_pc(in_pc), .in_ds(in_ds),
    .exc_set(exc_set), .exc_code(exc_code),
    .valid_q(valid_q), .ctrl_q(ctrl_q), .pc_q(pc_q), .ds_q(ds_q),
    .exc_take(exc_take), .exc_code_o(exc_code_o), .exc_epc(exc_epc),
    .exc_bd(exc_bd), .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = '0; flush = '0; exc_set = '0; exc_code = '0;
    in_valid = 1'b0; in_ctrl = '0; in_pc = '0; in_ds = 1'b0;
  endtask

  task automatic drain();
    idle();
    flush = '1;
    tick();
    flush = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0; in_valid = 1'b1; in_ctrl = 16'hFFFF; in_pc = 32'h1234;
    tick(); tick();
    n_checks++; if (valid_q !== 4'b0) begin n_fail++; $display("FAIL rst_valid got %h want 0", valid_q); end
    n_checks++; if (ctrl_q !== '0) begin n_fail++; $display("FAIL rst_ctrl got %h want 0", ctrl_q); end
    n_checks++; if (pc_q !== '0) begin n_fail++; $display("FAIL rst_pc got %h want 0", pc_q); end
    n_checks++; if ({ds_q, exc_take, exc_bd} !== 6'b0) begin n_fail++; $display("FAIL rst_flags got %b want 0", {ds_q, exc_take, exc_bd}); end
    n_checks++; if ({exc_code_o, exc_epc, exc_cnt} !== '0) begin n_fail++; $display("FAIL rst_exc got %h want 0", {exc_code_o, exc_epc, exc_cnt}); end
    rst = 1'b1; in_ctrl = 16'hA5A5; in_pc = 32'h100;
    tick();
    n_checks++; if (valid_q !== 4'b0001 || ctrl_q[15:0] !== 16'hA5A5) begin n_fail++; $display("FAIL lat_s0 got %b/%h want 0001/a5a5", valid_q, ctrl_q[15:0]); end
    in_valid = 1'b0; in_ctrl = 16'hFFFF;
    tick();
    n_checks++; if (valid_q !== 4'b0010 || ctrl_q[15:0] !== 16'h0) begin n_fail++; $display("FAIL bubble_s0 got %b/%h want 0010/0000", valid_q, ctrl_q[15:0]); end
    tick(); tick();
    n_checks++; if (valid_q !== 4'b1000 || ctrl_q[63:48] !== 16'hA5A5 || pc_q[127:96] !== 32'h100) begin
      n_fail++; $display("FAIL lat_s3 got %b/%h/%h want 1000/a5a5/100", valid_q, ctrl_q[63:48], pc_q[127:96]); end
  endtask

  task automatic test_stall();
    drain();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_ctrl = CW'(k); in_pc = PW'(32'h10 + 4*k);
      tick();
    end
    in_ctrl = 16'd5;
    stall = 4'b0011;
    tick();
    n_checks++; if (valid_q !== 4'b1011 || ctrl_q !== {16'd2, 16'd0, 16'd3, 16'd4}) begin
      n_fail++; $display("FAIL stall1 got %b/%h want 1011/0002000000030004", valid_q, ctrl_q); end
    tick();
    n_checks++; if (valid_q !== 4'b0011 || ctrl_q !== {16'd0, 16'd0, 16'd3, 16'd4}) begin
      n_fail++; $display("FAIL stall2 got %b/%h want 0011/0000000000030004", valid_q, ctrl_q); end
    stall = '0; in_valid = 1'b0;
    tick();
    n_checks++; if (valid_q !== 4'b0110 || ctrl_q !== {16'd0, 16'd3, 16'd4, 16'd0}) begin
      n_fail++; $display("FAIL unstall got %b/%h want 0110/0000000300040000", valid_q, ctrl_q); end
    tick();
    n_checks++; if (valid_q[3] !== 1'b1 || ctrl_q[63:48] !== 16'd3) begin n_fail++; $display("FAIL order3 got %b/%h want 1/0003", valid_q[3], ctrl_q[63:48]); end
    tick();
    n_checks++; if (valid_q[3] !== 1'b1 || ctrl_q[63:48] !== 16'd4) begin n_fail++; $display("FAIL order4 got %b/%h want 1/0004", valid_q[3], ctrl_q[63:48]); end
  endtask

  task automatic test_exc_basic();
    drain();
    exc_set = 4'b0001; exc_code[4:0] = 5'h1F;
    tick(); tick();
    n_checks++; if (exc_take !== 1'b0 || exc_cnt !== 8'd0) begin n_fail++; $display("FAIL exc_invalid got %b/%0d want 0/0", exc_take, exc_cnt); end
    idle();
    in_valid = 1'b1; in_ctrl = 16'h0003; in_pc = 32'h200;
    tick();
    in_valid = 1'b0; exc_set = 4'b0001; exc_code[4:0] = 5'h0A;
    tick();
    exc_set = '0; exc_code = '0;
    tick();
    n_checks++; if ({exc_take, exc_code_o, exc_epc, exc_bd} !== {1'b1, 5'h0A, 32'h200, 1'b0}) begin
      n_fail++; $display("FAIL exc_commit got %b/%h/%h/%b want 1/0a/200/0", exc_take, exc_code_o, exc_epc, exc_bd); end
    tick();
    n_checks++; if (valid_q !== 4'b0 || exc_take !== 1'b0 || exc_cnt !== 8'd1) begin
      n_fail++; $display("FAIL exc_after got %b/%b/%0d want 0000/0/1", valid_q, exc_take, exc_cnt); end
  endtask

  task automatic test_exc_ds();
    drain();
    in_valid = 1'b1; in_ds = 1'b1; in_pc = 32'h304; in_ctrl = 16'h0044;
    tick();
    idle();
    tick();
    exc_set = 4'b0010; exc_code[9:5] = 5'h04;
    tick();
    exc_set = '0; exc_code = '0;
    n_checks++; if ({exc_take, exc_code_o, exc_epc, exc_bd} !== {1'b1, 5'h04, 32'h300, 1'b1}) begin
      n_fail++; $display("FAIL exc_ds got %b/%h/%h/%b want 1/04/300/1", exc_take, exc_code_o, exc_epc, exc_bd); end
    tick();
    n_checks++; if (exc_cnt !== 8'd2) begin n_fail++; $display("FAIL cnt2 got %0d want 2", exc_cnt); end
  endtask

  task automatic test_first_wins();
    drain();
    in_valid = 1'b1; in_pc = 32'h400; in_ctrl = 16'h0055;
    tick();
    idle();
    exc_set = 4'b0001; exc_code[4:0] = 5'h0A;
    tick();
    exc_set = 4'b0010; exc_code = '0; exc_code[9:5] = 5'h0C;
    tick();
    exc_set = '0; exc_code = '0;
    n_checks++; if ({exc_take, exc_code_o, exc_epc} !== {1'b1, 5'h0A, 32'h400}) begin
      n_fail++; $display("FAIL first_wins got %b/%h/%h want 1/0a/400", exc_take, exc_code_o, exc_epc); end
    tick();
    n_checks++; if (exc_cnt !== 8'd3) begin n_fail++; $display("FAIL cnt3 got %0d want 3", exc_cnt); end
  endtask

  task automatic test_kill_stall_sat();
    int cyc;
    drain();
    in_valid = 1'b1; exc_set = 4'b0100; exc_code[14:10] = 5'h11;
    cyc = 0;
    while (exc_cnt != 8'hFF && cyc < 2000) begin
      tick();
      cyc++;
    end
    n_checks++; if (exc_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_reach got %h want ff after %0d cycles", exc_cnt, cyc); end
    drain();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_ctrl = CW'(16'h60 + k); in_pc = PW'(32'h600 + 4*k);
      tick();
    end
    n_checks++; if (valid_q !== 4'b1111 || exc_take !== 1'b0) begin n_fail++; $display("FAIL fill got %b/%b want 1111/0", valid_q, exc_take); end
    stall = 4'b0100; flush = 4'b1000; exc_set = 4'b0100; exc_code = '0; exc_code[14:10] = 5'h11;
    #1;
    n_checks++; if ({exc_take, exc_code_o, exc_epc} !== {1'b1, 5'h11, 32'h604}) begin
      n_fail++; $display("FAIL kill_take got %b/%h/%h want 1/11/604", exc_take, exc_code_o, exc_epc); end
    tick();
    idle();
    n_checks++; if (valid_q !== 4'b0 || exc_cnt !== 8'hFF) begin n_fail++; $display("FAIL kill_after got %b/%h want 0000/ff", valid_q, exc_cnt); end
  endtask

  task automatic test_reset_dominates();
    in_valid = 1'b1; in_pc = 32'h700;
    tick(); tick(); tick();
    rst = 1'b0; stall = '1; exc_set = 4'b0111; exc_code = '1;
    tick();
    n_checks++; if (valid_q !== 4'b0 || exc_cnt !== 8'd0 || exc_take !== 1'b0) begin
      n_fail++; $display("FAIL rst_dom got %b/%h/%b want 0000/00/0", valid_q, exc_cnt, exc_take); end
    idle();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_exc_basic();
    test_exc_ds();
    test_first_wins();
    test_kill_stall_sat();
    test_reset_dominates();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_exc.md
Name: ctrl_pipe_exc

Overview:
Parametrised control-bundle pipeline for the MIPS core, carrying decoded control signals, PC and delay-slot flag through STAGES register stages (D→E→M→W by default).
- Per-stage stall/flush with automatic bubble insertion.
- Per-stage exception injection with first-exception-wins stickiness.
- Precise exception commit at a configurable stage: EPC/BD generation, self-flush of younger stages, saturating exception counter.
- Replaces hand-instantiated per-stage flop chains in the controller.

Parameters:
CW, 16, control bundle width per stage
STAGES, 4, number of pipeline register stages (≥2); stage 0 = D
PC_W, 32, PC width
EXC_STAGE, 2, stage index at which exceptions commit (0 ≤ EXC_STAGE < STAGES)
CNT_W, 8, width of saturating exception counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
stall  in  STAGES  per-stage hold; bit s holds stage s
flush  in  STAGES  per-stage clear; bit s clears stage s
in_valid  in  1  instruction present at stage-0 input
in_ctrl  in  CW  control bundle from decoder
in_pc  in  PC_W  PC of incoming instruction
in_ds  in  1  incoming instruction is in a branch/jump delay slot
exc_set  in  STAGES  bit s: exception detected for instruction in stage s
exc_code  in  5*STAGES  ExcCode for stage s at bits [5s+4:5s]
valid_q  out  STAGES  per-stage valid
ctrl_q  out  CW*STAGES  per-stage control, stage s at [CW*s+CW-1:CW*s]
pc_q  out  PC_W*STAGES  per-stage PC
ds_q  out  STAGES  per-stage delay-slot flag
exc_take  out  1  exception committed this cycle
exc_code_o  out  5  committed ExcCode
exc_epc  out  PC_W  EPC for committed exception
exc_bd  out  1  Cause.BD for committed exception
exc_cnt  out  CNT_W  saturating count of committed exceptions

Behaviour:
- Reset (rst=0 at edge):
  - All valid, ctrl, pc, ds, sticky-exception flags and codes → 0.
  - exc_cnt → 0.
  - exc_take, exc_code_o, exc_epc, exc_bd are all 0 because the commit stage is invalid.
  - Reset dominates every other input, including mid-stall or mid-exception.
- Per-stage update at each edge, priority highest first:
  1. Reset.
  2. exc_kill (stage s ≤ EXC_STAGE): clear.
  3. flush[s]: clear.
  4. stall[s]: hold.
  5. Bubble: s>0 and stage s−1 stalled (stall[s−1]=1), or s−1 ≤ EXC_STAGE while exc_kill → load valid=0, ctrl=0, exc=0.
  6. Otherwise load from stage s−1; stage 0 loads the in_* ports.
- "Clear" means valid=0, ctrl=0, ds=0, exc flag=0, code=0. pc is don't-care when invalid, but the implementation zeroes it.
- Latency: one cycle per stage when stall=0. in_* appear at stage-0 outputs one edge after capture.
- in_valid=0 at stage 0 loads a bubble; in_ctrl is zeroed regardless of its value.
- Exception stickiness:
  - Stage s exception state on load = (incoming sticky flag) OR (exc_set[s−1] & valid of s−1).
  - Code is taken from the oldest detection: the incoming sticky code if already set, else exc_code[s−1].
  - Stage 0 loads flag=0.
  - exc_set[s] applied to an invalid stage is ignored.
  - At EXC_STAGE itself, the effective exception is sticky | exc_set[EXC_STAGE]; the sticky code has priority.
- Commit (combinational, from EXC_STAGE registers):
  - exc_take = valid[EXC_STAGE] & effective exception.
  - exc_code_o = effective code.
  - exc_bd = ds_q[EXC_STAGE].
  - exc_epc = pc − 4 if exc_bd, else pc.
  - All four outputs are 0 when exc_take=0.
- exc_kill = exc_take. It is applied even if stall[EXC_STAGE]=1, since exceptions override stall.
  - Stages 0..EXC_STAGE clear at the next edge.
  - Stage EXC_STAGE+1 (if it exists) loads a bubble.
  - Older stages advance normally.
- exc_cnt increments on each edge with exc_take=1 and saturates at 2^CNT_W−1.
- Simultaneous events:
  - flush and stall on the same stage: flush wins.
  - exc_set at a stage > EXC_STAGE is ignored.
  - Stalled stage with exc_set: the flag is captured into that stage's own sticky state. While held, the stage ORs exc_set[s] into its own sticky flag (code keeps the first one).

Test Plan:
1. Reset held 2 cycles with in_valid=1, in_ctrl=16'hFFFF → all outputs 0; after release, in_ctrl=16'hA5A5, pc=32'h100 → ctrl_q stage 3 = 16'hA5A5 and pc 32'h100 after 4 edges.
2. stall=4'b0011 for 2 cycles → stages 0,1 hold; stage 2 receives bubbles (valid_q[2]=0, ctrl=0) for 2 cycles; no instruction duplicated or lost.
3. exc_set[0] with code 5'h0A at pc=32'h200, not in delay slot → 2 edges later exc_take=1, exc_code_o=5'h0A, exc_epc=32'h200, exc_bd=0; next cycle valid_q[2:0]=0, valid_q[3]=0, exc_cnt=1.
4. Delay-slot instruction (in_ds=1, pc=32'h304) with exc_set[1] code 5'h04 → exc_epc=32'h300, exc_bd=1.
5. exc_set[0] code 5'h0A, then exc_set[1] code 5'h0C on the same instruction → exc_code_o=5'h0A (first wins).
6. exc_take while stall[2]=1 and flush[3]=1 → stages 0–2 cleared, stage 3 cleared; counter preset to 8'hFF stays 8'hFF.
